// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the bit-serial adder
package serial_adder_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int SA_WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE} state_e;
endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: gate-level one-bit full adder
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic S,
  output logic Cout
);
  logic x;
  assign x    = a ^ b;
  assign S    = x ^ cin;
  assign Cout = (a & b) | (x & cin);
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, LSB first through one full-adder cell (signed overflow when SERIAL_ADDER_OVF_EN is defined)
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q;
  logic [CW-1:0]    cnt_q;
  logic             fa_s, fa_co, last;
  serial_fa_cell u_fa (.a(a_q[0]), .b(b_q[0]), .cin(carry_q), .S(fa_s), .Cout(fa_co));
  assign last = cnt_q == CW'(WIDTH - 1);
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif
  // Sequencer: load on accepted start, one bit per edge in RUN, single-cycle DONE; counter is cleared on the last bit so it never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q     <= a_in;
          b_q     <= b_in;
          carry_q <= cin_in;
          cnt_q   <= '0;
          sum_q   <= '0;
          cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_q   <= 1'b0;
`endif
          state_q <= RUN;
        end
        RUN: begin
          sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_co;
          cnt_q   <= last ? '0 : cnt_q + CW'(1);
          if (last) begin
            cout_q  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= carry_q ^ fa_co;
`endif
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random checks of the bit-serial adder (WIDTH=8)
module tb_serial_adder_ctrl;
`ifdef SERIAL_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic       cin_in = 1'b0;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;
  int n_tests = 0;
  int n_fail  = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Accept one start, then count edges until done (bounded) and busy cycles on the way
  task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                         output int lat, output int busy_n);
    @(negedge clk);
    a_in = a; b_in = b; cin_in = c; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a_in = ~a; b_in = ~b; cin_in = ~c;
    lat = 0; busy_n = 0;
    while (done !== 1'b1 && lat < 40) begin
      busy_n += int'(busy);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    #3;
    n_tests++;
    if ({busy, done, sum, cout, ovf} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0", busy, done, sum, cout, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_vector(input string name, input logic [7:0] a, input logic [7:0] b, input logic c,
                             input logic [7:0] exp_s, input logic exp_c, input logic exp_v_if_en);
    int lat, bn;
    logic exp_v;
    exp_v = OVF_ON & exp_v_if_en;
    run_add(a, b, c, lat, bn);
    n_tests++;
    if (lat !== 8) begin n_fail++; $display("FAIL %s_latency: got %0d edges, want 8", name, lat); end
    n_tests++;
    if (bn !== 8) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d, want 8", name, bn); end
    n_tests++;
    if (sum !== exp_s || cout !== exp_c || ovf !== exp_v) begin
      n_fail++;
      $display("FAIL %s_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b", name, sum, cout, ovf, exp_s, exp_c, exp_v);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || sum !== exp_s || cout !== exp_c) begin
      n_fail++;
      $display("FAIL %s_hold: got done=%b sum=%h cout=%b, want done=0 sum=%h cout=%b", name, done, sum, cout, exp_s, exp_c);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bn, errs;
    logic [7:0] a, b, exp_s;
    logic c, exp_c, exp_v;
    logic [8:0] full;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      full  = {1'b0, a} + {1'b0, b} + {8'd0, c};
      exp_s = full[7:0]; exp_c = full[8];
      exp_v = OVF_ON & (a[7] == b[7]) & (exp_s[7] != a[7]);
      run_add(a, b, c, lat, bn);
      n_tests++;
      if (lat !== 8 || sum !== exp_s || cout !== exp_c || ovf !== exp_v) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL random_%0d: a=%h b=%h cin=%b got lat=%0d sum=%h cout=%b ovf=%b, want lat=8 sum=%h cout=%b ovf=%b",
                   i, a, b, c, lat, sum, cout, ovf, exp_s, exp_c, exp_v);
      end
    end
  endtask

  task automatic test_ignore_start;
    int dones;
    @(negedge clk);
    a_in = 8'h12; b_in = 8'h34; cin_in = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int k = 0; k < 16; k++) begin
      start = (k == 3);
      a_in = 8'hAA; b_in = 8'h55; cin_in = 1'b0;
      dones += int'(done);
      if (done === 1'b1) begin
        n_tests++;
        if (sum !== 8'h47 || cout !== 1'b0) begin
          n_fail++;
          $display("FAIL ignore_start_result: got sum=%h cout=%b, want sum=47 cout=0", sum, cout);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_tests++;
    if (dones !== 1) begin n_fail++; $display("FAIL ignore_start_done_count: got %0d, want 1", dones); end
  endtask

  task automatic test_reset_mid;
    int lat, bn;
    @(negedge clk);
    a_in = 8'hF0; b_in = 8'h0F; cin_in = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, sum, cout, ovf} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0", busy, done, sum, cout, ovf);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
    run_add(8'h3C, 8'h42, 1'b0, lat, bn);
    n_tests++;
    if (lat !== 8 || sum !== 8'h7E || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got lat=%0d sum=%h cout=%b ovf=%b, want lat=8 sum=7e cout=0 ovf=0", lat, sum, cout, ovf);
    end
  endtask

  initial begin
    test_reset;
    test_vector("add_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    test_vector("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    test_vector("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    test_vector("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    test_vector("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    test_back_to_back;
    test_ignore_start;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder front end for the one-bit full-adder cell. It loads two WIDTH-bit operands plus a carry-in, then feeds one bit pair per clock, LSB first, into a single full-adder cell. The carry is registered between bits, and the sum is shifted into a result register. It sits directly upstream of the full-adder cell and drives its a/b/cin inputs. On the board, the switches supply the operands and the LEDs show the result.

Parameters:
- WIDTH, 8, operand and sum width in bits (≥2).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request to begin an addition; sampled only in IDLE.
- a_in  in  WIDTH  operand A, captured on the accepting edge.
- b_in  in  WIDTH  operand B, captured on the accepting edge.
- cin_in  in  1  carry-in, captured on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result is valid.
- sum  out  WIDTH  result, held until the next accepted start.
- cout  out  1  final carry-out, held with sum.
- ovf  out  1  signed overflow (see Optional Feature).

Behaviour:
- Reset: asynchronous, takes effect immediately, including mid-operation.
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Operand shift registers, carry register and bit counter are cleared.
- States: IDLE, RUN, DONE. Encoding is 2 bits: IDLE=0, RUN=1, DONE=2. The unused code 3 recovers to IDLE.
- IDLE:
  - If start=1 at a rising edge: load a_sh<=a_in, b_sh<=b_in, carry<=cin_in, cnt<=0, and clear sum. Go to RUN.
  - Otherwise stay in IDLE.
- RUN, on each edge:
  - The full-adder cell computes S/Cout from a_sh[0], b_sh[0] and carry.
  - sum shifts right with S entering the MSB.
  - a_sh and b_sh shift right with 0 filled in.
  - carry<=Cout and cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: cout<=Cout and go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally. start is ignored in DONE.
- Latency: if start is accepted at edge t0, RUN occupies edges t1..tWIDTH, and done is high during the cycle after edge tWIDTH.
  - Throughput is one addition per WIDTH+2 cycles.
- busy and done are decoded from the registered state, with no combinational path from inputs.
- start asserted while in RUN or DONE is ignored. The operands in flight are unaffected, and start is not queued.
- a_in, b_in and cin_in changing after the accepting edge have no effect.
- Arithmetic: {cout,sum} = a_in + b_in + cin_in, modulo 2^(WIDTH+1).
- cnt is $clog2(WIDTH) bits wide and never wraps during RUN.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - On the final RUN edge, ovf <= carry ^ Cout, i.e. the carry into the MSB XOR the carry out of the MSB.
  - ovf is held with sum and cleared on accepted start and on reset.
- Undefined: ovf is tied to 0 and no extra logic is generated. The port is present in both builds.

Decomposition:
- Shared package serial_adder_pkg:
  - state encoding localparams ST_IDLE, ST_RUN, ST_DONE;
  - default width constant SA_WIDTH_DEF=8.
- One sub-module, serial_fa_cell: a gate-level one-bit full adder. Inputs a, b, cin; outputs S, Cout.
  - x = a^b
  - S = x^cin
  - Cout = (a&b)|(x&cin)
  - Exactly one instance, fed from the shift-register LSBs and the carry register.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, cin=0, start for one cycle -> busy high for 8 cycles; done pulses 8 cycles after the accept edge; sum=0x08, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. With SERIAL_ADDER_OVF_EN: ovf=0.
- a=0x7F, b=0x01, cin=0 with SERIAL_ADDER_OVF_EN -> sum=0x80, cout=0, ovf=1. Without the macro: ovf=0.
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then random a/b/cin back-to-back (1000 runs), compared against the {cout,sum} reference model.
- Pulse start again at cycle 3 of RUN with different operands -> ignored; the result matches the first operands; exactly one done pulse.
- Assert rst at cycle 4 of RUN for a partial cycle -> outputs are zero immediately and the state is IDLE; a new start after release completes correctly.
